// File: rtl/instr_fetch_if.sv
// Program-memory port of the instruction fetch sequencer: single-outstanding
// byte read request with a separate response strobe.
interface instr_fetch_if #(
   parameter int IP_W = 8
);
   logic [IP_W-1:0] mem_addr;
   logic            mem_rd;
   logic [7:0]      mem_rdata;
   logic            mem_valid;

   modport master (
      output mem_addr,
      output mem_rd,
      input  mem_rdata,
      input  mem_valid
   );

   modport slave (
      input  mem_addr,
      input  mem_rd,
      output mem_rdata,
      output mem_valid
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode/immediate bytes, issues one opcode
// per issue cycle, owns IP, jumps and halt. Define IFETCH_HALT_EN to make 8'hFE halt.
//
// state     | meaning
// FETCH_OP  | strobe read of opcode byte at ip
// WAIT_OP   | wait for opcode response, ip+1
// FETCH_IMM | strobe read of immediate byte at ip
// WAIT_IMM  | wait for immediate response, ip+1
// ISSUE     | present opcode once stall is low; jump/halt decided here
// HALT      | idle until run
module instr_fetch #(
   parameter int IP_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   instr_fetch_if.master   mem,
   input  logic            stall,
   input  logic            run,
   output logic [7:0]      instr,
   output logic [7:0]      imm,
   output logic            instr_valid,
   output logic            halted,
   output logic [IP_W-1:0] ip_out
);

   typedef enum logic [2:0] {
      FETCH_OP,
      WAIT_OP,
      FETCH_IMM,
      WAIT_IMM,
      ISSUE,
      HALT
   } state_t;

   state_t          state;
   logic [IP_W-1:0] ip;
   logic [7:0]      op_reg;
   logic [7:0]      imm_reg;
   logic            rd_q;
   logic            issue;

   function automatic logic is_two_byte(input logic [7:0] op);
      return (op[7:3] == 5'b00000) || (op[7:6] == 2'b01) || (op == 8'h80);
   endfunction

`ifdef IFETCH_HALT_EN
   logic halt_q;
`else
   logic unused_run;
   assign unused_run = run;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH_OP;
         ip      <= '0;
         op_reg  <= 8'hFF;
         imm_reg <= 8'h00;
         rd_q    <= 1'b0;
`ifdef IFETCH_HALT_EN
         halt_q  <= 1'b0;
`endif
      end else begin
         case (state)
            // Reset lands here with the strobe low; the first cycle raises it.
            FETCH_OP: begin
               if (rd_q) begin
                  rd_q  <= 1'b0;
                  state <= WAIT_OP;
               end else begin
                  rd_q <= 1'b1;
               end
            end
            WAIT_OP: begin
               if (mem.mem_valid) begin
                  op_reg <= mem.mem_rdata;
                  ip     <= ip + IP_W'(1);
                  if (is_two_byte(mem.mem_rdata)) begin
                     rd_q  <= 1'b1;
                     state <= FETCH_IMM;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            FETCH_IMM: begin
               rd_q  <= 1'b0;
               state <= WAIT_IMM;
            end
            WAIT_IMM: begin
               if (mem.mem_valid) begin
                  imm_reg <= mem.mem_rdata;
                  ip      <= ip + IP_W'(1);
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (!stall) begin
                  if (op_reg == 8'h80) ip <= IP_W'(imm_reg);
`ifdef IFETCH_HALT_EN
                  if (op_reg == 8'hFE) begin
                     halt_q <= 1'b1;
                     state  <= HALT;
                  end else begin
                     rd_q  <= 1'b1;
                     state <= FETCH_OP;
                  end
`else
                  rd_q  <= 1'b1;
                  state <= FETCH_OP;
`endif
               end
            end
            HALT: begin
`ifdef IFETCH_HALT_EN
               if (run) begin
                  halt_q <= 1'b0;
                  rd_q   <= 1'b1;
                  state  <= FETCH_OP;
               end
`else
               rd_q  <= 1'b1;
               state <= FETCH_OP;
`endif
            end
            default: begin
               rd_q  <= 1'b0;
               state <= FETCH_OP;
            end
         endcase
      end
   end

   // Outside the single issue cycle the decoder sees NOP, so it never double-registers.
   assign issue       = (state == ISSUE) && !stall;
   assign instr       = issue ? op_reg : 8'hFF;
   assign instr_valid = issue;
   assign imm         = imm_reg;
   assign ip_out      = ip;
   assign mem.mem_addr = ip;
   assign mem.mem_rd   = rd_q;

`ifdef IFETCH_HALT_EN
   assign halted = halt_q;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: opcode-class table, directed corner
// sequences, and randomized programs against a transaction-level model.
`timescale 1ns/1ps
module tb_instr_fetch;
   localparam int N = 600;
`ifdef IFETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       run = 1'b0;
   logic [7:0] instr, imm, ip_out;
   logic       instr_valid, halted;

   instr_fetch_if #(.IP_W(8)) mem_if ();

   instr_fetch #(.IP_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem         (mem_if.master),
      .stall       (stall),
      .run         (run),
      .instr       (instr),
      .imm         (imm),
      .instr_valid (instr_valid),
      .halted      (halted),
      .ip_out      (ip_out)
   );

   initial forever #5 clk = ~clk;

   logic [7:0] mem_img [256];
   int         lat = 1;
   int         wait_cnt = 0;
   logic [7:0] pend = 8'h00;
   int         cyc;
   int         vectors = 0;
   int         errors = 0;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   // Program memory with `lat` cycles of response latency; shares rst_n.
   initial begin
      mem_if.mem_valid = 1'b0;
      mem_if.mem_rdata = 8'h00;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            mem_if.mem_valid = 1'b0;
            wait_cnt = 0;
         end else begin
            mem_if.mem_valid = 1'b0;
            mem_if.mem_rdata = 8'($urandom);
            if (wait_cnt > 0) begin
               wait_cnt--;
               if (wait_cnt == 0) begin
                  mem_if.mem_valid = 1'b1;
                  mem_if.mem_rdata = mem_img[pend];
               end
            end
            if (mem_if.mem_rd) begin
               pend = mem_if.mem_addr;
               wait_cnt = lat;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic fill_mem(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem_img[i] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0;
      run   = 1'b0;
      #1;
      check("rst_instr", instr, 8'hFF);
      check("rst_imm", imm, 8'h00);
      check("rst_valid", instr_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_mem_rd", mem_if.mem_rd, 0);
      check("rst_mem_addr", mem_if.mem_addr, 0);
      check("rst_ip", ip_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_issue(input int max, output int at);
      at = -1;
      for (int i = 0; i < max && at < 0; i++) begin
         @(negedge clk); #1;
         if (instr_valid) at = cyc;
      end
   endtask

   task automatic wait_rd(input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max && !found; i++) begin
         @(negedge clk); #1;
         if (mem_if.mem_rd) found = 1'b1;
      end
   endtask

   function automatic bit two_byte(input logic [7:0] op);
      return op inside {[8'h00:8'h07], [8'h40:8'h7F], 8'h80};
   endfunction

   function automatic logic [7:0] rand_op();
      case ($urandom_range(0, 9))
         0:       return 8'($urandom_range(0, 7));
         1, 2:    return 8'($urandom_range(8'h40, 8'h7F));
         3:       return 8'h80;
         4:       return 8'hFE;
         default: return 8'($urandom);
      endcase
   endfunction

   // Reference model: walks the program instruction by instruction, adding
   // (latency + 1) cycles per byte fetched, waiting out stall/run patterns.
   bit         stall_pat [N];
   bit         run_pat   [N];
   bit         e_rd      [N];
   logic [7:0] e_addr    [N];
   bit         e_valid   [N];
   logic [7:0] e_instr   [N];
   logic [7:0] e_imm     [N];
   logic [7:0] e_ip      [N];
   bit         e_halt    [N];

   task automatic build_model();
      logic [7:0] ip, op, im;
      int c;
      for (int k = 0; k < N; k++) begin
         e_rd[k] = 0; e_addr[k] = 0; e_valid[k] = 0; e_instr[k] = 8'hFF;
         e_imm[k] = 0; e_ip[k] = 0; e_halt[k] = 0;
      end
      ip = 0; im = 0; c = 1;
      while (c < N) begin
         e_rd[c] = 1; e_addr[c] = ip;
         op = mem_img[ip]; ip++; c += lat + 1;
         if (two_byte(op)) begin
            if (c < N) begin e_rd[c] = 1; e_addr[c] = ip; end
            im = mem_img[ip]; ip++; c += lat + 1;
         end
         while (c < N && stall_pat[c]) c++;
         if (c >= N) break;
         e_valid[c] = 1; e_instr[c] = op; e_imm[c] = im; e_ip[c] = ip;
         if (op == 8'h80) ip = im;
         c++;
         if (HALT_EN && op == 8'hFE) begin
            while (c < N && !run_pat[c]) begin e_halt[c] = 1; c++; end
            if (c < N) e_halt[c] = 1;
            c++;
         end
      end
   endtask

   typedef struct {
      logic [7:0] op;
      logic [7:0] imm_b;
      int         issue_cyc;
      logic [7:0] exp_imm;
      logic [7:0] next_addr;
      bit         halts;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int  at;
      bit  found;
      tbl[0]  = '{8'h00, 8'h11, 5, 8'h11, 8'h02, 1'b0};
      tbl[1]  = '{8'h07, 8'h22, 5, 8'h22, 8'h02, 1'b0};
      tbl[2]  = '{8'h08, 8'h33, 3, 8'h00, 8'h01, 1'b0};
      tbl[3]  = '{8'h3F, 8'h44, 3, 8'h00, 8'h01, 1'b0};
      tbl[4]  = '{8'h40, 8'h55, 5, 8'h55, 8'h02, 1'b0};
      tbl[5]  = '{8'h7F, 8'h66, 5, 8'h66, 8'h02, 1'b0};
      tbl[6]  = '{8'h80, 8'h10, 5, 8'h10, 8'h10, 1'b0};
      tbl[7]  = '{8'h81, 8'h77, 3, 8'h00, 8'h01, 1'b0};
      tbl[8]  = '{8'hFE, 8'h22, 3, 8'h00, 8'h01, HALT_EN};
      tbl[9]  = '{8'hFF, 8'h88, 3, 8'h00, 8'h01, 1'b0};
      tbl[10] = '{8'h21, 8'h99, 3, 8'h00, 8'h01, 1'b0};

      foreach (tbl[i]) begin
         fill_mem(8'h21);
         mem_img[0] = tbl[i].op;
         mem_img[1] = tbl[i].imm_b;
         lat = 1;
         do_reset();
         wait_issue(12, at);
         check("tbl_issue_cyc", at, tbl[i].issue_cyc);
         check("tbl_instr", instr, tbl[i].op);
         check("tbl_imm", imm, tbl[i].exp_imm);
         if (tbl[i].halts) begin
            repeat (3) @(negedge clk);
            #1;
            check("tbl_halted", halted, 1);
            check("tbl_halt_no_rd", mem_if.mem_rd, 0);
         end else begin
            wait_rd(4, found);
            check("tbl_next_rd_found", found, 1);
            check("tbl_next_addr", mem_if.mem_addr, tbl[i].next_addr);
         end
      end

      // Load-immediate then one-byte FF, 1-cycle latency.
      fill_mem(8'hF0);
      mem_img[0] = 8'h00; mem_img[1] = 8'h5A; mem_img[2] = 8'hFF;
      lat = 1;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         check("ldi_valid", instr_valid, (c == 5 || c == 8));
         check("ldi_instr", instr, (c == 5) ? 8'h00 : 8'hFF);
         check("ldi_rd", mem_if.mem_rd, (c == 1 || c == 3 || c == 6));
         if (mem_if.mem_rd) check("ldi_addr", mem_if.mem_addr, (c == 1) ? 0 : (c == 3) ? 1 : 2);
         if (c == 5) check("ldi_imm", imm, 8'h5A);
         if (c == 8) check("ldi_ip", ip_out, 8'h03);
      end

      // Stall held 4 cycles over an ISSUE of 21.
      fill_mem(8'hF0);
      mem_img[0] = 8'h21;
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         stall = (c >= 3 && c <= 6);
         #1;
         check("stall_valid", instr_valid, (c == 7));
         check("stall_instr", instr, (c == 7) ? 8'h21 : 8'hFF);
      end
      stall = 1'b0;

      // Halt byte followed by 22.
      fill_mem(8'hF0);
      mem_img[0] = 8'hFE; mem_img[1] = 8'h22;
      do_reset();
`ifdef IFETCH_HALT_EN
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         run = (c == 14);
         #1;
         check("halt_valid", instr_valid, (c == 3 || c == 17));
         check("halt_instr", instr, (c == 3) ? 8'hFE : (c == 17) ? 8'h22 : 8'hFF);
         check("halt_halted", halted, (c >= 4 && c <= 14));
         check("halt_rd", mem_if.mem_rd, (c == 1 || c == 15));
         if (c == 15) check("halt_resume_addr", mem_if.mem_addr, 8'h01);
      end
      run = 1'b0;
`else
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk); #1;
         check("nohalt_valid", instr_valid, (c == 3 || c == 6));
         check("nohalt_instr", instr, (c == 3) ? 8'hFE : (c == 6) ? 8'h22 : 8'hFF);
         check("nohalt_halted", halted, 0);
         if (c == 4) check("nohalt_addr", mem_if.mem_addr, 8'h01);
      end
`endif

      // Jump to FF, two-byte 45 whose immediate wraps to address 0.
      fill_mem(8'hF0);
      mem_img[0] = 8'h80; mem_img[1] = 8'hFF; mem_img[255] = 8'h45;
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); #1;
         check("wrap_valid", instr_valid, (c == 5 || c == 10));
         check("wrap_rd", mem_if.mem_rd, (c == 1 || c == 3 || c == 6 || c == 8));
         if (c == 6) check("wrap_addr_ff", mem_if.mem_addr, 8'hFF);
         if (c == 8) check("wrap_addr_00", mem_if.mem_addr, 8'h00);
         if (c == 10) begin
            check("wrap_instr", instr, 8'h45);
            check("wrap_imm", imm, 8'h80);
            check("wrap_ip", ip_out, 8'h01);
         end
      end

      // Reset while waiting for the second instruction's immediate.
      fill_mem(8'hF0);
      mem_img[0] = 8'h00; mem_img[1] = 8'h77; mem_img[2] = 8'h00; mem_img[3] = 8'h88;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         if (c == 8) begin
            check("rstmid_rd", mem_if.mem_rd, 1);
            check("rstmid_addr", mem_if.mem_addr, 8'h03);
            check("rstmid_imm", imm, 8'h77);
         end
      end
      do_reset();
      @(negedge clk); #1;
      check("rstmid_refetch_rd", mem_if.mem_rd, 1);
      check("rstmid_refetch_addr", mem_if.mem_addr, 8'h00);

      // Randomized programs, stall and run patterns against the model.
      for (int r = 0; r < 4; r++) begin
         lat = (r < 3) ? r + 1 : int'($urandom_range(1, 3));
         for (int i = 0; i < 256; i++) mem_img[i] = rand_op();
         for (int c = 0; c < N; c++) begin
            stall_pat[c] = ($urandom_range(0, 99) < 20);
            run_pat[c]   = ($urandom_range(0, 99) < 15);
         end
         build_model();
         do_reset();
         for (int c = 1; c < N; c++) begin
            @(negedge clk);
            stall = stall_pat[c];
            run   = run_pat[c];
            #1;
            check("rnd_rd", mem_if.mem_rd, e_rd[c]);
            if (e_rd[c]) check("rnd_addr", mem_if.mem_addr, e_addr[c]);
            check("rnd_valid", instr_valid, e_valid[c]);
            check("rnd_instr", instr, e_instr[c]);
            check("rnd_halted", halted, e_halt[c]);
            if (e_valid[c]) begin
               check("rnd_imm", imm, e_imm[c]);
               check("rnd_ip", ip_out, e_ip[c]);
            end
         end
         stall = 1'b0;
         run   = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
